// File: rtl/spi_wb_sequencer.sv
// spi_wb_sequencer: Wishbone master that configures simple_spi and shifts one client byte at a time through it.
module spi_wb_sequencer #(
  parameter logic [7:0]  SPCR_INIT  = 8'h50,
  parameter logic [7:0]  SPER_INIT  = 8'h00,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  input  logic       rsp_ready_i,
  output logic       busy_o,
  output logic       err_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [7:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);
  typedef enum logic [2:0] {CFG_OFF, CFG_EXT, CFG_ON, IDLE, WR_DAT, POLL, RD_DAT, TMO} state_t;
  localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);
  state_t      r_state, w_state_nxt;
  logic        r_cyc, r_we, r_rsp_valid, r_rsp_err, r_err;
  logic [7:0]  r_adr, r_dat, r_byte, r_rsp_data;
  logic [15:0] r_cnt;
  logic        w_bus, w_start, w_done, w_we, w_ready, w_req_fire, w_rsp_fire;
  logic [7:0]  w_adr, w_dat;
  logic [15:0] w_cnt_inc;
  assign w_ready    = r_state == IDLE && !r_rsp_valid;
  assign w_req_fire = w_ready && req_valid_i;
  assign w_rsp_fire = r_rsp_valid && rsp_ready_i;
  assign w_done     = r_cyc && wbm_ack_i;
  assign w_start    = w_bus && !r_cyc;
  assign w_cnt_inc  = r_cnt + 16'd1;
  always_comb begin
    w_state_nxt = r_state;
    w_bus = 1'b1;
    w_we  = 1'b1;
    w_adr = 8'd0;
    w_dat = 8'd0;
    case (r_state)
      CFG_OFF: begin
        w_dat = SPCR_INIT & 8'hBF;
        if (w_done) w_state_nxt = CFG_EXT;
      end
      CFG_EXT: begin
        w_adr = 8'd3;
        w_dat = SPER_INIT;
        if (w_done) w_state_nxt = CFG_ON;
      end
      CFG_ON: begin
        w_dat = SPCR_INIT;
        if (w_done) w_state_nxt = IDLE;
      end
      IDLE: begin
        w_bus = 1'b0;
        if (w_req_fire) w_state_nxt = WR_DAT;
      end
      WR_DAT: begin
        w_adr = 8'd2;
        w_dat = r_byte;
        if (w_done) w_state_nxt = POLL;
      end
      POLL: begin
        w_we  = 1'b0;
        w_adr = 8'd1;
        if (w_done) w_state_nxt = !wbm_dat_i[0] ? RD_DAT : w_cnt_inc == LIMIT ? TMO : POLL;
      end
      RD_DAT: begin
        w_we  = 1'b0;
        w_adr = 8'd2;
        if (w_done) w_state_nxt = IDLE;
      end
      default: begin
        w_bus = 1'b0;
        w_state_nxt = CFG_OFF;
      end
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state     <= CFG_OFF;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 8'd0;
      r_dat       <= 8'd0;
      r_byte      <= 8'd0;
      r_cnt       <= 16'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_rsp_err   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cyc <= 1'b1;
        r_we  <= w_we;
        r_adr <= w_adr;
        r_dat <= w_dat;
      end else if (w_done) begin
        r_cyc <= 1'b0;
      end
      if (w_req_fire) begin
        r_byte <= req_data_i;
        r_cnt  <= 16'd0;
      end else if (r_state == POLL && w_done && r_cnt != LIMIT) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == RD_DAT && w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= wbm_dat_i;
        r_rsp_err   <= 1'b0;
      end else if (r_state == TMO) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= 8'hFF;
        r_rsp_err   <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
      if (r_state == TMO) r_err <= 1'b1;
    end
  end
  assign req_ready_o = w_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = r_state != IDLE;
  assign err_o       = r_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
endmodule

// File: tb/tb_spi_wb_sequencer.sv
// tb_spi_wb_sequencer: scoreboard bench for spi_wb_sequencer against a behavioural simple_spi slave.
module tb_spi_wb_sequencer;
  localparam int LIMIT = 4;
  logic clk, rst_n, req_valid, req_ready, rsp_valid, rsp_err, rsp_ready, busy, err;
  logic cyc, stb, we, s_ack;
  logic [7:0] req_data, rsp_data, adr, dat_o, s_dat, s_rx;
  int n_checks = 0, n_fail = 0, rsp_fires = 0;
  int m_delay = 0, m_busy = 0, s_wait = 0, s_left = 0;
  logic [7:0] m_miso = 8'h00;
  bit m_stuck = 0;
  logic [16:0] bus_q[$];
  logic [8:0]  rsp_q[$];

  spi_wb_sequencer #(.POLL_LIMIT(LIMIT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .rsp_ready_i(rsp_ready), .busy_o(busy), .err_o(err), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(s_dat), .wbm_ack_i(s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave: registered ack after m_delay wait cycles; SPSR reports RFEMPTY for m_busy polls after each SPDR write.
  initial begin s_ack = 1'b0; s_dat = 8'h00; s_rx = 8'h00; end
  always @(posedge clk) begin
    if (!rst_n) begin
      s_ack <= 1'b0; s_wait <= 0; s_left <= 0;
    end else if (s_ack) begin
      s_ack <= 1'b0; s_wait <= 0;
    end else if (cyc && stb) begin
      if (s_wait < m_delay) s_wait <= s_wait + 1;
      else begin
        s_ack <= 1'b1;
        if (we && adr == 8'd2) begin s_left <= m_busy; s_rx <= m_miso; end
        s_dat <= we ? 8'h00 : adr == 8'd1 ? ((m_stuck || s_left != 0) ? 8'h05 : 8'h04) : adr == 8'd2 ? s_rx : 8'h00;
        if (!we && adr == 8'd1 && s_left != 0) s_left <= s_left - 1;
      end
    end
  end

  logic pv_cyc = 1'b0, pv_ack = 1'b0, stable = 1'b0;
  logic [16:0] acc;
  logic [17:0] b_got, b_exp;
  always @(negedge clk) begin
    if (pv_cyc && pv_ack) check("gap", cyc, 1'b0);
    if (cyc && (!pv_cyc || pv_ack)) begin acc = {we, adr, dat_o}; stable = 1'b1; end
    else if (cyc && acc !== {we, adr, dat_o}) stable = 1'b0;
    if (cyc && s_ack) begin
      check("stable", stable, 1'b1);
      check("stb", stb, cyc);
      b_got = {1'b1, we, adr, we ? dat_o : 8'h00};
      if (bus_q.size() != 0) b_exp = {1'b1, bus_q.pop_front()};
      else b_exp = 18'h0;
      check("bus", b_got, b_exp);
    end
    pv_cyc = cyc;
    pv_ack = s_ack;
  end

  logic [9:0] r_got, r_exp;
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rsp_fires++;
      r_got = {1'b1, rsp_err, rsp_data};
      if (rsp_q.size() != 0) r_exp = {1'b1, rsp_q.pop_front()};
      else r_exp = 10'h0;
      check("rsp", r_got, r_exp);
    end
  end

  task automatic push_bus(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus_q.push_back({w, a, w ? d : 8'h00});
  endtask

  task automatic push_cfg();
    push_bus(1'b1, 8'd0, 8'h10);
    push_bus(1'b1, 8'd3, 8'h00);
    push_bus(1'b1, 8'd0, 8'h50);
  endtask

  task automatic offer(input logic [7:0] d);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data  = d;
  endtask

  task automatic accept(input logic [7:0] d, input logic [7:0] miso, input int nb, input bit tmo);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    check("accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_busy = nb; m_miso = miso; m_stuck = tmo;
    push_bus(1'b1, 8'd2, d);
    if (tmo) begin
      repeat (LIMIT) push_bus(1'b0, 8'd1, 8'h00);
      rsp_q.push_back({1'b1, 8'hFF});
      push_cfg();
    end else begin
      repeat (nb + 1) push_bus(1'b0, 8'd1, 8'h00);
      push_bus(1'b0, 8'd2, 8'h00);
      rsp_q.push_back({1'b0, miso});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    check(tag, req_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d0;
    int bad, fires0, n;
    rst_n = 1'b0; req_valid = 1'b0; req_data = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", cyc, 1'b0);
    check("rst_rsp", rsp_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    push_cfg();
    rst_n = 1'b1;
    wait_idle("cfg_idle");
    // Single byte with two busy polls before RX data lands.
    offer(8'hA5);
    accept(8'hA5, 8'h3C, 2, 1'b0);
    wait_idle("a5_idle");
    // Second request waits behind a stalled response.
    rsp_ready = 1'b0;
    offer(8'h01);
    accept(8'h01, 8'h81, 1, 1'b0);
    offer(8'h02);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    check("rsp1_seen", rsp_valid, 1'b1);
    d0 = rsp_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready || !rsp_valid || rsp_data !== d0) bad++;
    end
    check("hold", bad, 0);
    check("hold_data", d0, 8'h81);
    fires0 = rsp_fires;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    accept(8'h02, 8'h42, 0, 1'b0);
    check("order", rsp_fires, fires0 + 1);
    wait_idle("b2b_idle");
    // Timeout: RFEMPTY never clears.
    offer(8'h77);
    accept(8'h77, 8'h00, 0, 1'b1);
    wait_idle("tmo_idle");
    check("err_sticky", err, 1'b1);
    // Reset mid-poll.
    offer(8'h11);
    accept(8'h11, 8'h00, 0, 1'b1);
    n = 0;
    @(posedge clk); #1;
    while (!(cyc && adr == 8'd1) && n < 500) begin @(posedge clk); #1; n++; end
    check("poll_seen", {cyc, adr}, 9'h101);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_cyc", cyc, 1'b0);
    check("mid_stb", stb, 1'b0);
    check("mid_rsp", rsp_valid, 1'b0);
    check("mid_err", err, 1'b0);
    bus_q.delete();
    rsp_q.delete();
    push_cfg();
    m_stuck = 1'b0;
    rst_n = 1'b1;
    wait_idle("rst_idle");
    // Slow slave.
    m_delay = 7;
    offer(8'hC3);
    accept(8'hC3, 8'h5A, 1, 1'b0);
    wait_idle("slow_idle");
    repeat (3) @(negedge clk);
    check("bus_left", bus_q.size(), 0);
    check("rsp_left", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
